// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over a req/ack
// handshake, buffers a word returned during a stall and drains a fetch orphaned by a redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_pc4,
    output logic [31:0] pc_IF,
    output logic [31:0] IF_inst,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        REQ,
        HOLD,
        DRAIN
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] inst_buf, inst_buf_nxt;
    logic [31:0] tgt, tgt_nxt;
    logic [31:0] redir_aligned;

    assign redir_aligned = {redirect_pc[31:2], 2'b00};
    assign imem_addr     = pc;
    assign pc_IF         = pc;
    assign IF_pc4        = pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= REQ;
            pc       <= RESET_PC;
            inst_buf <= '0;
            tgt      <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            inst_buf <= inst_buf_nxt;
            tgt      <= tgt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        inst_buf_nxt = inst_buf;
        tgt_nxt      = tgt;
        imem_req     = 1'b0;
        if_valid     = 1'b0;
        IF_inst      = '0;
        case (state)
            REQ: begin
                // rst gating keeps outputs quiet and ignores acks during async reset
                imem_req = !rst;
                if_valid = imem_ack && !redirect && !rst;
                IF_inst  = if_valid ? imem_rdata : '0;
                if (imem_ack) begin
                    if (redirect) begin
                        pc_nxt = redir_aligned;
                    end else if (!stall) begin
                        pc_nxt = pc + 32'd4;
                    end else begin
                        inst_buf_nxt = imem_rdata;
                        state_nxt    = HOLD;
                    end
                end else if (redirect) begin
                    tgt_nxt   = redir_aligned;
                    state_nxt = DRAIN;
                end
            end
            HOLD: begin
                if_valid = 1'b1;
                IF_inst  = inst_buf;
                if (redirect) begin
                    pc_nxt    = redir_aligned;
                    state_nxt = REQ;
                end else if (!stall) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                imem_req = !rst;
                if (redirect) begin
                    tgt_nxt = redir_aligned;
                end
                // latest redirect wins even when it coincides with the draining ack
                if (imem_ack) begin
                    pc_nxt    = redirect ? redir_aligned : tgt;
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a wait-state memory and a flag-level
// model of the instruction stream (pending word, orphaned fetch) predict every output.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IF_pc4;
    logic [31:0] pc_IF;
    logic [31:0] IF_inst;
    logic        if_valid;

    int checks = 0;
    int errors = 0;

    // model state: next instruction address in program order, a buffered
    // instruction waiting for hand-off, and an orphaned access still in flight
    logic [31:0] m_pc;
    logic        m_buf;
    logic        m_stale;
    logic [31:0] m_stale_addr;
    int          mcnt;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .IF_pc4(IF_pc4),
        .pc_IF(pc_IF),
        .IF_inst(IF_inst),
        .if_valid(if_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".pc_IF"}, pc_IF, RST_PC);
        check({tag, ".IF_pc4"}, IF_pc4, RST_PC + 32'd4);
        check({tag, ".imem_addr"}, imem_addr, RST_PC);
        check({tag, ".imem_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, ".if_valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, ".IF_inst"}, IF_inst, 32'd0);
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_buf   = 1'b0;
        m_stale = 1'b0;
        m_stale_addr = '0;
        mcnt    = -1;
    endtask

    // One cycle: drive inputs after the falling edge, let the memory answer,
    // compare all outputs against the model, then advance the model.
    task automatic step(input logic s, input logic r, input logic [31:0] rp,
                        input int unsigned wlo, input int unsigned whi);
        logic [31:0] e_addr;
        logic        e_valid;
        logic        ack_now;
        @(negedge clk);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        ack_now     = 1'b0;
        if (!m_buf) begin
            if (mcnt < 0) mcnt = int'($urandom_range(whi, wlo));
            ack_now = (mcnt == 0);
            mcnt = ack_now ? -1 : mcnt - 1;
        end
        imem_ack   = ack_now;
        imem_rdata = ack_now ? ~imem_addr : 32'hDEAD_BEEF;
        #2;
        e_addr  = m_stale ? m_stale_addr : m_pc;
        e_valid = m_buf || (ack_now && !m_stale && !r);
        check("imem_req", {31'd0, imem_req}, {31'd0, !m_buf});
        check("imem_addr", imem_addr, e_addr);
        check("pc_IF", pc_IF, e_addr);
        check("IF_pc4", IF_pc4, e_addr + 32'd4);
        check("if_valid", {31'd0, if_valid}, {31'd0, e_valid});
        check("IF_inst", IF_inst, e_valid ? ~m_pc : 32'd0);

        if (r) begin
            if (m_buf) begin
                m_buf = 1'b0;
            end else if (ack_now) begin
                m_stale = 1'b0;
            end else if (!m_stale) begin
                m_stale      = 1'b1;
                m_stale_addr = m_pc;
            end
            m_pc = {rp[31:2], 2'b00};
        end else if (m_buf) begin
            if (!s) begin
                m_buf = 1'b0;
                m_pc  = m_pc + 32'd4;
            end
        end else if (ack_now) begin
            if (m_stale) m_stale = 1'b0;
            else if (s) m_buf = 1'b1;
            else m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        logic [31:0] rp;
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        model_reset();

        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_reset_req", {31'd0, imem_req}, 32'd1);

        // zero-wait streaming, then 2-wait-state memory
        repeat (8) step(1'b0, 1'b0, '0, 0, 0);
        repeat (12) step(1'b0, 1'b0, '0, 2, 2);
        // stall across a zero-wait ack, then release
        repeat (3) step(1'b1, 1'b0, '0, 0, 0);
        repeat (3) step(1'b0, 1'b0, '0, 0, 0);
        // redirect while waiting, drained through a 2-cycle access
        step(1'b0, 1'b0, '0, 2, 2);
        step(1'b0, 1'b1, 32'h0000_2002, 2, 2);
        repeat (4) step(1'b0, 1'b0, '0, 0, 0);
        // stall into HOLD, then redirect+stall toward the wrap point
        repeat (2) step(1'b1, 1'b0, '0, 0, 0);
        step(1'b1, 1'b1, 32'hFFFF_FFFE, 0, 0);
        repeat (4) step(1'b0, 1'b0, '0, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            rp = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 15, rp, 0, 3);
        end

        // reset in the middle of an outstanding access, with a late ack
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 0, 0);
        step(1'b0, 1'b0, '0, 3, 3);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(posedge clk);
        #1 check_reset_outputs("ack_in_reset");
        @(negedge clk);
        imem_ack = 1'b0;
        rst      = 1'b0;
        #1 check("rerelease_req", {31'd0, imem_req}, 32'd1);
        check("rerelease_addr", imem_addr, RST_PC);
        model_reset();
        repeat (6) step(1'b0, 1'b0, '0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
